dadda_seq_mult_8_ctrl: RTL and testbench

- Sequencer that computes one 8x8 multiply (unsigned or signed) as four passes through a single shared 4x4 Dadda multiplier core.
- Each pass feeds one nibble pair to the core and shift-accumulates the 8-bit partial product.
- The core sits outside this block, attached through core_a/core_b/core_p; this block holds only control, operand, accumulator and sign-fixup logic.
- Upstream and downstream connect through valid/ready handshakes.

---
 rtl/dadda_seq_mult_8_ctrl.sv | 175 +++++++++++++++++
 tb/tb_dadda_seq_mult_8_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dadda_seq_mult_8_ctrl.sv
// dadda_seq_mult_8_ctrl
//   Sequencer that forms one 8x8 product (unsigned or two's complement) by
//   making four passes through an external, shared 4x4 Dadda multiplier core.
//   Operands are converted to magnitudes on accept, the four nibble-pair
//   partial products are shift-accumulated, and the sign is applied when the
//   last partial product lands.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake (in_ready registered)
//   in_a, in_b            8-bit operands
//   in_signed             1 = two's complement operands, 0 = unsigned
//   out_valid/out_ready   product handshake
//   p                     16-bit product (registered, stable until taken)
//   core_a, core_b        nibbles driven to the 4x4 core
//   core_p                8-bit combinational product returned by the core
//
// Parameter
//   EARLY_ZERO            1 = a zero operand skips the multiply passes
module dadda_seq_mult_8_ctrl #(
    parameter bit EARLY_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    input  logic        in_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] p,
    output logic [3:0]  core_a,
    output logic [3:0]  core_b,
    input  logic [7:0]  core_p
);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t      state, state_nxt;
    logic [7:0]  ma, mb;
    logic        neg;
    logic [15:0] acc;
    logic [1:0]  step;
    logic [15:0] term;
    logic [15:0] sum;
    logic        accept;
    logic        zero_op;

    // Magnitude of an operand; -128 maps to 8'h80, which is correct as unsigned.
    function automatic logic [7:0] mag8(input logic [7:0] v, input logic is_signed);
        logic signed [7:0] sv;
        sv = v;
        if (is_signed && (sv < 0))
            return ~v + 8'd1;
        return v;
    endfunction

    // Two's-complement negation modulo 2^16 when the product is negative.
    function automatic logic [15:0] apply_sign(input logic [15:0] m, input logic n);
        return n ? (~m + 16'd1) : m;
    endfunction

    // in_ready is only ever high in IDLE, so no state qualifier is needed.
    assign accept  = in_valid && in_ready;
    assign zero_op = (in_a == 8'd0) || (in_b == 8'd0);
    assign sum     = acc + term;

    // Nibble selection and partial-product alignment for the current pass.
    always_comb begin
        core_a = 4'd0;
        core_b = 4'd0;
        term   = 16'd0;
        if (state == MUL) begin
            case (step)
                2'd0: begin
                    core_a = ma[3:0];
                    core_b = mb[3:0];
                    term   = {8'd0, core_p};
                end
                2'd1: begin
                    core_a = ma[7:4];
                    core_b = mb[3:0];
                    term   = {4'd0, core_p, 4'd0};
                end
                2'd2: begin
                    core_a = ma[3:0];
                    core_b = mb[7:4];
                    term   = {4'd0, core_p, 4'd0};
                end
                default: begin
                    core_a = ma[7:4];
                    core_b = mb[7:4];
                    term   = {core_p, 8'd0};
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = (EARLY_ZERO && zero_op) ? DONE : MUL;
            end
            MUL: begin
                if (step == 2'd3)
                    state_nxt = DONE;
            end
            DONE: begin
                if (out_valid && out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            p         <= 16'd0;
            acc       <= 16'd0;
            step      <= 2'd0;
            ma        <= 8'd0;
            mb        <= 8'd0;
            neg       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ma       <= mag8(in_a, in_signed);
                        mb       <= mag8(in_b, in_signed);
                        neg      <= in_signed & (in_a[7] ^ in_b[7]);
                        acc      <= 16'd0;
                        step     <= 2'd0;
                        in_ready <= 1'b0;
                        if (EARLY_ZERO && zero_op)
                            p <= 16'd0;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                MUL: begin
                    acc  <= sum;
                    step <= step + 2'd1;
                    if (step == 2'd3) begin
                        p         <= apply_sign(sum, neg);
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // The zero shortcut enters DONE with out_valid still low;
                    // it rises one edge after the accept.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dadda_seq_mult_8_ctrl.sv
module tb_dadda_seq_mult_8_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready, in_signed, out_valid, out_ready;
    logic [7:0]  in_a, in_b;
    logic [15:0] p;
    logic [3:0]  core_a, core_b;
    logic [7:0]  core_p;

    logic        iv0, ir0, ov0;
    logic [15:0] p0;
    logic [3:0]  ca0, cb0;
    logic [7:0]  cp0;

    always #5 clk = ~clk;

    assign core_p = {4'd0, core_a} * {4'd0, core_b};
    assign cp0    = {4'd0, ca0} * {4'd0, cb0};

    dadda_seq_mult_8_ctrl #(.EARLY_ZERO(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
        .out_valid(out_valid), .out_ready(out_ready), .p(p),
        .core_a(core_a), .core_b(core_b), .core_p(core_p)
    );

    dadda_seq_mult_8_ctrl #(.EARLY_ZERO(1'b0)) dut_nz (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv0), .in_ready(ir0),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
        .out_valid(ov0), .out_ready(1'b1), .p(p0),
        .core_a(ca0), .core_b(cb0), .core_p(cp0)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_acc = -1;
    int n_acc = 0;
    int n_out = 0;
    bit b2b = 1'b0;
    logic [15:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    function automatic logic [15:0] ref_mult(input logic [7:0] a, input logic [7:0] b, input logic s);
        int ia, ib;
        ia = s ? int'($signed(a)) : int'(a);
        ib = s ? int'($signed(b)) : int'(b);
        return 16'(ia * ib);
    endfunction

    function automatic logic [3:0] ref_nib(input logic [7:0] v, input logic s, input bit hi);
        int iv;
        logic [7:0] m;
        iv = s ? int'($signed(v)) : int'(v);
        if (iv < 0) iv = -iv;
        m = 8'(iv);
        return hi ? m[7:4] : m[3:0];
    endfunction

    // Scoreboard: push on accept, pop on output handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_mult(in_a, in_b, in_signed));
                n_acc++;
                if (b2b && last_acc >= 0) check("b2b_interval", cyc - last_acc, 6);
                last_acc = cyc;
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sb_unexpected: output p=0x%0h with nothing pending", p);
                end else begin
                    check("sb_product", int'(p), int'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic do_txn(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic [15:0] exp, input string name);
        int w, lat;
        bit zs;
        zs = (a == 8'd0) || (b == 8'd0);
        w = 0;
        while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
        check({name, "_ready"}, int'(in_ready), 1);
        in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({name, "_in_ready_low"}, int'(in_ready), 0);
        lat = 0;
        while (!out_valid && lat < 50) begin
            if (lat < 4) begin
                check({name, "_core_a"}, int'(core_a),
                      zs ? 0 : int'(ref_nib(a, s, (lat == 1) || (lat == 3))));
                check({name, "_core_b"}, int'(core_b),
                      zs ? 0 : int'(ref_nib(b, s, lat >= 2)));
            end
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, lat, zs ? 1 : 4);
        check({name, "_p"}, int'(p), int'(exp));
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int w, lat;
        vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_ff_ff"};
        vecs[1]  = '{8'h80, 8'h80, 1'b1, 16'h4000, "s_m128_m128"};
        vecs[2]  = '{8'h80, 8'h7F, 1'b1, 16'hC080, "s_m128_127"};
        vecs[3]  = '{8'hFD, 8'h05, 1'b1, 16'hFFF1, "s_m3_5"};
        vecs[4]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001, "s_m1_m1"};
        vecs[5]  = '{8'h80, 8'hFF, 1'b0, 16'h7F80, "u_80_ff"};
        vecs[6]  = '{8'h80, 8'h01, 1'b1, 16'hFF80, "s_m128_1"};
        vecs[7]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01, "s_127_127"};
        vecs[8]  = '{8'h00, 8'hA5, 1'b0, 16'h0000, "zero_a"};
        vecs[9]  = '{8'h5B, 8'h00, 1'b1, 16'h0000, "zero_b_s"};
        vecs[10] = '{8'hFE, 8'hFE, 1'b1, 16'h0004, "s_m2_m2"};
        vecs[11] = '{8'h12, 8'h34, 1'b0, 16'h03A8, "u_12_34"};

        in_valid = 1'b0; iv0 = 1'b0; out_ready = 1'b1;
        in_a = 8'd0; in_b = 8'd0; in_signed = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_p", int'(p), 0);
        check("rst_core_a", int'(core_a), 0);
        rst_n = 1'b1;
        #1;
        check("rst_rel_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        check("first_edge_in_ready", int'(in_ready), 1);

        // Table-driven vectors
        for (int i = 0; i < 12; i++)
            do_txn(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, vecs[i].name);
        @(posedge clk); #1;

        // Zero operand without the shortcut takes the full four passes
        w = 0;
        while (!ir0 && w < 50) begin @(posedge clk); #1; w++; end
        in_a = 8'h00; in_b = 8'hA5; in_signed = 1'b0; iv0 = 1'b1;
        @(posedge clk); #1;
        iv0 = 1'b0;
        lat = 0;
        while (!ov0 && lat < 50) begin
            check("nz_core_a", int'(ca0), 0);
            @(posedge clk); #1;
            lat++;
        end
        check("nz_latency", lat, 4);
        check("nz_p", int'(p0), 0);

        // Back-pressure
        out_ready = 1'b0;
        do_txn(8'h12, 8'h34, 1'b0, 16'h03A8, "bp");
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_a = 8'($urandom_range(1, 255));
            in_b = 8'($urandom_range(1, 255));
            @(posedge clk); #1;
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_p", int'(p), 16'h03A8);
            check("bp_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_out_valid", int'(out_valid), 0);
        check("bp_release_in_ready", int'(in_ready), 1);

        // Reset during step 2
        in_a = 8'h55; in_b = 8'h66; in_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_core_b_step2", int'(core_b), 4'h6);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_p", int'(p), 0);
        check("mid_rst_in_ready", int'(in_ready), 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", int'(in_ready), 1);
        do_txn(8'h03, 8'h04, 1'b0, 16'h000C, "post_rst");
        @(posedge clk); #1;

        // Back-to-back random stream
        b2b = 1'b1; last_acc = -1; n_acc = 0; n_out = 0;
        in_a = 8'($urandom_range(1, 255));
        in_b = 8'($urandom_range(1, 255));
        in_signed = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            w = 0;
            while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
            if (!in_ready) begin
                n_cmp++; n_fail++;
                $display("FAIL b2b_accept_timeout: in_ready=0 expected 1 at txn %0d", i);
            end
            @(posedge clk); #1;
            in_a = 8'($urandom_range(1, 255));
            in_b = 8'($urandom_range(1, 255));
            in_signed = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        w = 0;
        while (n_out < 100 && w < 100) begin @(posedge clk); #1; w++; end
        check("b2b_accepts", n_acc, 100);
        check("b2b_outputs", n_out, 100);
        check("b2b_queue_empty", exp_q.size(), 0);
        b2b = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
